// File: rtl/cache_flush_manager_if.sv
// Handshake bundle for the FENCE.I cache-flush responder.
// The slave modport is the flush manager's view; master is the view of
// the surrounding pipeline, DCache and ICache.
interface cache_flush_manager_if #(
  parameter int DCACHE_INDEX_WIDTH = 7,
  parameter int DCACHE_WAY_WIDTH   = 1,
  parameter int PERF_COUNT_WIDTH   = 32
);
  // Requester side
  logic                          cacheFlushReq;
  logic                          cacheFlushComplete;
  logic                          pipelineClear;
  // DCache side
  logic                          mshrBusy;
  logic                          flushBusy;
  logic                          dcLineFlushReq;
  logic [DCACHE_INDEX_WIDTH-1:0] dcLineFlushIndex;
  logic [DCACHE_WAY_WIDTH-1:0]   dcLineFlushWay;
  logic                          dcLineFlushAck;
  // ICache side
  logic                          icFlushReq;
  logic                          icFlushDone;
  // Performance counters (zero unless the counter feature is built in)
  logic [PERF_COUNT_WIDTH-1:0]   flushCount;
  logic [PERF_COUNT_WIDTH-1:0]   lastFlushCycles;

  modport slave (
    input  cacheFlushReq, pipelineClear, mshrBusy, dcLineFlushAck, icFlushDone,
    output cacheFlushComplete, flushBusy, dcLineFlushReq, dcLineFlushIndex,
           dcLineFlushWay, icFlushReq, flushCount, lastFlushCycles
  );

  modport master (
    output cacheFlushReq, pipelineClear, mshrBusy, dcLineFlushAck, icFlushDone,
    input  cacheFlushComplete, flushBusy, dcLineFlushReq, dcLineFlushIndex,
           dcLineFlushWay, icFlushReq, flushCount, lastFlushCycles
  );
endinterface

// File: rtl/cache_flush_manager.sv
// Responder side of the FENCE.I cache-flush handshake.
// Waits for DCache MSHRs to drain, walks every DCache line (write back and
// invalidate, one line per cycle at most), invalidates the ICache, then holds
// cacheFlushComplete until the requester re-presents the request or the
// pipeline clears.
// Optional feature macro: CACHE_FLUSH_PERF_COUNTER_EN adds a completed-flush
// counter and a last-flush cycle length; without it both outputs read 0.
module cache_flush_manager #(
  parameter int DCACHE_INDEX_WIDTH = 7,
  parameter int DCACHE_WAY_WIDTH   = 1,
  parameter int PERF_COUNT_WIDTH   = 32
) (
  input logic                   clk,
  input logic                   rst,
  cache_flush_manager_if.slave  bus
);

  localparam int LINE_W = DCACHE_INDEX_WIDTH + DCACHE_WAY_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_MSHR = 3'd1,
    S_DC_WALK   = 3'd2,
    S_IC_FLUSH  = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              busy_q, busy_d;
  logic              line_req_q, line_req_d;
  logic              ic_req_q, ic_req_d;
  logic              complete_q, complete_d;

  // Next-state and next-output decode; outputs are decoded from the next
  // state so every output comes straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    line_d  = line_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cacheFlushReq) begin
          state_d = S_WAIT_MSHR;
          line_d  = '0;
        end
      end
      S_WAIT_MSHR: begin
        if (!bus.mshrBusy) state_d = S_DC_WALK;
      end
      S_DC_WALK: begin
        // The line request is always up in this state, so an ack here is
        // always for the presented line; the counter wraps to 0 on the last.
        if (bus.dcLineFlushAck) begin
          line_d = line_q + LINE_W'(1);
          if (&line_q) state_d = S_IC_FLUSH;
        end
      end
      S_IC_FLUSH: begin
        if (bus.icFlushDone) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.cacheFlushReq || bus.pipelineClear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_WAIT_MSHR) || (state_d == S_DC_WALK) ||
                 (state_d == S_IC_FLUSH);
    line_req_d = (state_d == S_DC_WALK);
    ic_req_d   = (state_d == S_IC_FLUSH);
    complete_d = (state_d == S_DONE);
  end

  // State, line counter and registered outputs; reset drops everything at once.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (!rst) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      busy_q     <= 1'b0;
      line_req_q <= 1'b0;
      ic_req_q   <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      line_req_q <= line_req_d;
      ic_req_q   <= ic_req_d;
      complete_q <= complete_d;
    end
  end

  assign bus.flushBusy          = busy_q;
  assign bus.dcLineFlushReq     = line_req_q;
  assign bus.dcLineFlushIndex   = line_q[DCACHE_INDEX_WIDTH-1:0];
  assign bus.dcLineFlushWay     = line_q[LINE_W-1 -: DCACHE_WAY_WIDTH];
  assign bus.icFlushReq         = ic_req_q;
  assign bus.cacheFlushComplete = complete_q;

`ifdef CACHE_FLUSH_PERF_COUNTER_EN
  logic [PERF_COUNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [PERF_COUNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [PERF_COUNT_WIDTH-1:0] last_q, last_d;

  // Cycle counter covers WAIT_MSHR through the final IC_FLUSH cycle; on entry
  // to DONE the length is latched and the completed-flush count bumps.
  always_comb begin
    cyc_d  = cyc_q;
    fcnt_d = fcnt_q;
    last_d = last_q;
    if (state_q == S_IDLE) begin
      cyc_d = '0;
    end else if ((state_q != S_DONE) && !(&cyc_q)) begin
      cyc_d = cyc_q + PERF_COUNT_WIDTH'(1);
    end
    if ((state_q == S_IC_FLUSH) && bus.icFlushDone) begin
      last_d = (&cyc_q) ? cyc_q : cyc_q + PERF_COUNT_WIDTH'(1);
      if (!(&fcnt_q)) fcnt_d = fcnt_q + PERF_COUNT_WIDTH'(1);
    end
  end

  // Performance counter flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q  <= '0;
      fcnt_q <= '0;
      last_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      fcnt_q <= fcnt_d;
      last_q <= last_d;
    end
  end

  assign bus.flushCount      = fcnt_q;
  assign bus.lastFlushCycles = last_q;
`else
  assign bus.flushCount      = '0;
  assign bus.lastFlushCycles = '0;
`endif

endmodule

// File: tb/tb_cache_flush_manager.sv
// Bench for cache_flush_manager with 4 sets x 2 ways (8 lines).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed latency, ordering and counter expectations.
module tb_cache_flush_manager;

  localparam int IW     = 2;
  localparam int WW     = 1;
  localparam int PW     = 32;
  localparam int NSETS  = 1 << IW;
  localparam int NLINES = 1 << (IW + WW);

`ifdef CACHE_FLUSH_PERF_COUNTER_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_flush_manager_if #(
    .DCACHE_INDEX_WIDTH(IW), .DCACHE_WAY_WIDTH(WW), .PERF_COUNT_WIDTH(PW)
  ) bus ();

  cache_flush_manager #(
    .DCACHE_INDEX_WIDTH(IW), .DCACHE_WAY_WIDTH(WW), .PERF_COUNT_WIDTH(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase of the flush as seen by the outside world.
  localparam logic [2:0] PH_IDLE = 3'd0, PH_DRAIN = 3'd1, PH_LINES = 3'd2,
                         PH_ICACHE = 3'd3, PH_FINISHED = 3'd4;

  typedef struct packed {
    logic [2:0]  ph;
    logic [31:0] line;   // number of lines already written back
    logic [31:0] cyc;    // cycles spent flushing so far
    logic [31:0] cnt;    // completed flushes
    logic [31:0] last;   // length of the last completed flush
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input logic req, input logic clr,
                                        input logic mshr, input logic ack, input logic done);
    model_t n = c;
    if (c.ph != PH_IDLE && c.ph != PH_FINISHED) n.cyc = c.cyc + 1;
    case (c.ph)
      PH_IDLE:     if (req) begin n.ph = PH_DRAIN; n.line = 0; n.cyc = 0; end
      PH_DRAIN:    if (!mshr) n.ph = PH_LINES;
      PH_LINES:    if (ack) begin
                     n.line = c.line + 1;
                     if (n.line == NLINES) begin n.line = 0; n.ph = PH_ICACHE; end
                   end
      PH_ICACHE:   if (done) begin n.ph = PH_FINISHED; n.last = n.cyc; n.cnt = c.cnt + 1; end
      PH_FINISHED: if (req || clr) n.ph = PH_IDLE;
      default:     n.ph = PH_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst) m <= '0;
    else m <= model_next(m, bus.cacheFlushReq, bus.pipelineClear, bus.mshrBusy,
                         bus.dcLineFlushAck, bus.icFlushDone);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.flushBusy),
            64'(m.ph == PH_DRAIN || m.ph == PH_LINES || m.ph == PH_ICACHE));
      check("line_req", 64'(bus.dcLineFlushReq), 64'(m.ph == PH_LINES));
      check("index", 64'(bus.dcLineFlushIndex), 64'(int'(m.line) % NSETS));
      check("way", 64'(bus.dcLineFlushWay), 64'(int'(m.line) / NSETS));
      check("ic_req", 64'(bus.icFlushReq), 64'(m.ph == PH_ICACHE));
      check("complete", 64'(bus.cacheFlushComplete), 64'(m.ph == PH_FINISHED));
      check("flush_count", 64'(bus.flushCount), PERF_EN ? 64'(m.cnt) : 64'd0);
      check("last_cycles", 64'(bus.lastFlushCycles), PERF_EN ? 64'(m.last) : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int stall_line = -1, stall_len = 0, stall_cnt = 0;
  int line2_cycles = 0, last_line = -1;
  int first_line_cyc = -1, first_done_cyc = -1, c0 = 0;
  bit ic_seen = 1'b0, stray_ack = 1'b0, stray_done = 1'b0;
  int acked[$];

  // Advance to the next falling edge and play DCache / ICache responders.
  task automatic step();
    int ln;
    @(negedge clk);
    last_line = -1;
    bus.dcLineFlushAck = stray_ack;
    if (bus.dcLineFlushReq) begin
      ln = int'(bus.dcLineFlushWay) * NSETS + int'(bus.dcLineFlushIndex);
      last_line = ln;
      if (ln == 2) line2_cycles++;
      if (first_line_cyc < 0) first_line_cyc = cyc;
      if (ln == stall_line && stall_cnt < stall_len) begin
        stall_cnt++;
        bus.dcLineFlushAck = 1'b0;
      end else begin
        bus.dcLineFlushAck = 1'b1;
        acked.push_back(ln);
      end
    end
    // ICache finishes one cycle after it first sees the request.
    if (bus.icFlushReq) begin
      bus.icFlushDone = ic_seen;
      ic_seen = 1'b1;
    end else begin
      bus.icFlushDone = stray_done;
      ic_seen = 1'b0;
    end
    if (bus.cacheFlushComplete && first_done_cyc < 0) first_done_cyc = cyc;
  endtask

  task automatic start_flush();
    step();
    acked.delete();
    first_line_cyc = -1;
    first_done_cyc = -1;
    line2_cycles   = 0;
    bus.cacheFlushReq = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && first_done_cyc < 0; i++) step();
    check({name, "_done_seen"}, 64'(first_done_cyc >= 0), 64'd1);
  endtask

  task automatic wait_line(input int ln, input string name);
    for (int i = 0; i < 200 && last_line != ln; i++) step();
    check({name, "_line_seen"}, 64'(last_line), 64'(ln));
  endtask

  // Requester re-presents the request in DONE, then withdraws it.
  task automatic claim(input string name);
    step();
    check({name, "_claim_complete"}, 64'(bus.cacheFlushComplete), 64'd0);
    check({name, "_claim_busy"}, 64'(bus.flushBusy), 64'd0);
    bus.cacheFlushReq = 1'b0;
  endtask

  task automatic check_order(input string name);
    check({name, "_ack_total"}, 64'(acked.size()), 64'(NLINES));
    foreach (acked[i]) check({name, "_line_order"}, 64'(acked[i]), 64'(i));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(bus.flushBusy), 64'd0);
    check({name, "_line_req"}, 64'(bus.dcLineFlushReq), 64'd0);
    check({name, "_index"}, 64'(bus.dcLineFlushIndex), 64'd0);
    check({name, "_way"}, 64'(bus.dcLineFlushWay), 64'd0);
    check({name, "_ic_req"}, 64'(bus.icFlushReq), 64'd0);
    check({name, "_complete"}, 64'(bus.cacheFlushComplete), 64'd0);
    check({name, "_count"}, 64'(bus.flushCount), 64'd0);
    check({name, "_last"}, 64'(bus.lastFlushCycles), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    bus.cacheFlushReq  = 1'b0;
    bus.pipelineClear  = 1'b0;
    bus.mshrBusy       = 1'b0;
    bus.dcLineFlushAck = 1'b0;
    bus.icFlushDone    = 1'b0;

    do_reset();
    chk_en = 1'b1;
    check_all_zero("reset");

    // 1: plain flush, ack every cycle.
    start_flush();
    wait_done("t1");
    check("t1_first_line_latency", 64'(first_line_cyc - c0), 64'd2);
    check("t1_complete_latency", 64'(first_done_cyc - c0), 64'd12);
    check_order("t1");
    claim("t1");
    repeat (3) step();

    // 2: MSHRs busy for 5 cycles; stray ack/done while draining are ignored.
    start_flush();
    bus.mshrBusy = 1'b1;
    stray_ack = 1'b1;
    stray_done = 1'b1;
    repeat (5) begin
      step();
      check("t2_busy_while_drain", 64'(bus.flushBusy), 64'd1);
      check("t2_no_line_while_drain", 64'(bus.dcLineFlushReq), 64'd0);
    end
    bus.mshrBusy = 1'b0;
    stray_ack = 1'b0;
    stray_done = 1'b0;
    wait_done("t2");
    check("t2_first_line_latency", 64'(first_line_cyc - c0), 64'd6);
    check_order("t2");
    claim("t2");
    repeat (2) step();

    // 3: line 2 stalls three cycles before its ack.
    stall_line = 2; stall_len = 3; stall_cnt = 0;
    start_flush();
    wait_done("t3");
    check("t3_line2_cycles", 64'(line2_cycles), 64'd4);
    check("t3_complete_latency", 64'(first_done_cyc - c0), 64'd15);
    check_order("t3");
    claim("t3");
    stall_line = -1;
    repeat (2) step();

    // 4: request dropped mid-walk, flush finishes and is released by a clear.
    start_flush();
    wait_line(4, "t4");
    bus.cacheFlushReq = 1'b0;
    wait_done("t4");
    repeat (4) begin
      step();
      check("t4_complete_held", 64'(bus.cacheFlushComplete), 64'd1);
    end
    check_order("t4");
    bus.pipelineClear = 1'b1;
    step();
    bus.pipelineClear = 1'b0;
    check("t4_complete_after_clear", 64'(bus.cacheFlushComplete), 64'd0);
    check("t4_busy_after_clear", 64'(bus.flushBusy), 64'd0);
    repeat (3) step();

    // 5: reset in the middle of the walk, then a clean restart.
    start_flush();
    wait_line(5, "t5");
    bus.cacheFlushReq = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_all_zero("t5_midwalk_reset");
    start_flush();
    wait_done("t5");
    check("t5_first_line_latency", 64'(first_line_cyc - c0), 64'd2);
    check_order("t5");
    claim("t5");
    repeat (2) step();

    // 6: two back-to-back plain flushes from reset; counters depend on build.
    do_reset();
    check_all_zero("t6_reset");
    for (int k = 0; k < 2; k++) begin
      start_flush();
      wait_done("t6");
      check("t6_complete_latency", 64'(first_done_cyc - c0), 64'd12);
      claim("t6");
      step();
    end
    check("t6_flush_count", 64'(bus.flushCount), PERF_EN ? 64'd2 : 64'd0);
    check("t6_last_cycles", 64'(bus.lastFlushCycles), PERF_EN ? 64'd11 : 64'd0);

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
